stopwatch_ctrl: RTL and testbench

- Button-driven control sequencer for the stopwatch datapath. Sits between two raw push-buttons and the BCD up-counter / FND display path.
- Debounces both buttons and runs a STOP/RUN/LAP/CLEAR state machine.
- Generates the run and clear controls plus a prescaled count tick for the up-counter.
- Selects live or lap-frozen count value for the FND controller.

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, count and display signals of the stopwatch controller
interface stopwatch_ctrl_if #(
  parameter int DIGIT_W = 14
);
  logic               btn_run;
  logic               btn_clr;
  logic [DIGIT_W-1:0] i_count;
  logic               o_run_on;
  logic               o_clr_on;
  logic               o_tick;
  logic [DIGIT_W-1:0] o_digit;
  logic               o_lap;
  logic [1:0]         o_state;

  modport master (
    output btn_run, btn_clr, i_count,
    input  o_run_on, o_clr_on, o_tick, o_digit, o_lap, o_state
  );

  modport slave (
    input  btn_run, btn_clr, i_count,
    output o_run_on, o_clr_on, o_tick, o_digit, o_lap, o_state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - debounced STOP/RUN/LAP/CLEAR sequencer with count-tick prescaler
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CLK_DIV   = 1_000_000,
  parameter int DIGIT_W   = 14
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int PS_W = $clog2(CLK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               lap_capture;
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         db;
  logic [1:0]         press;
  logic [DB_W-1:0]    db_cnt [2];
  logic [PS_W-1:0]    presc;
  logic [DIGIT_W-1:0] lap_q;
  logic               run_ev;
  logic               clr_ev;
  logic               run_on;

  // Bit 0 is the run button, bit 1 the clear/lap button.
  assign raw = {sw.btn_clr, sw.btn_run};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A run press in the same cycle as a clear press takes priority.
  assign run_ev = press[0];
  assign clr_ev = press[1] & ~press[0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_STOP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    lap_capture = 1'b0;
    case (state)
      ST_STOP: begin
        if (run_ev)      state_nx = ST_RUN;
        else if (clr_ev) state_nx = ST_CLEAR;
      end
      ST_RUN: begin
        if (run_ev) begin
          state_nx = ST_STOP;
        end else if (clr_ev) begin
          state_nx    = ST_LAP;
          lap_capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (run_ev)      state_nx = ST_STOP;
        else if (clr_ev) state_nx = ST_RUN;
      end
      default: state_nx = ST_STOP;
    endcase
  end

  assign run_on = (state == ST_RUN) || (state == ST_LAP);

  // Prescaler holds in STOP so a resumed run keeps its sub-tick fraction.
  always_ff @(posedge clk) begin
    if (reset || state == ST_CLEAR) begin
      presc <= '0;
    end else if (run_on) begin
      if (presc == PS_LAST) presc <= '0;
      else                  presc <= presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            lap_q <= '0;
    else if (lap_capture) lap_q <= sw.i_count;
  end

  assign sw.o_run_on = run_on;
  assign sw.o_clr_on = (state == ST_CLEAR);
  assign sw.o_lap    = (state == ST_LAP);
  assign sw.o_state  = state;
  assign sw.o_tick   = run_on && (presc == PS_LAST);
  assign sw.o_digit  = (state == ST_LAP) ? lap_q : sw.i_count;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_stopwatch_ctrl;
  localparam int DB  = 4;
  localparam int DIV = 10;

  logic clk;
  logic reset;
  stopwatch_ctrl_if #(.DIGIT_W(14)) sw ();

  stopwatch_ctrl #(
    .DB_CYCLES (DB),
    .CLK_DIV   (DIV),
    .DIGIT_W   (14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_log [$];

  // Reference model: debounced level flips once DB consecutive synchronized samples disagree with it.
  int          m_state;
  bit          m_db [2];
  bit          m_ev [2];
  int          m_run_total;
  logic [13:0] m_lap;
  bit          q_run [$];
  bit          q_clr [$];

  function automatic bit window_flips(input bit q[$], input bit level);
    for (int j = 0; j < DB; j++)
      if (q[q.size() - 3 - j] == level) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit run_ev, clr_ev, run_now;
    if (reset) begin
      m_state = 0; m_run_total = 0; m_lap = '0;
      m_db = '{0, 0}; m_ev = '{0, 0};
      q_run.delete(); q_clr.delete();
      for (int i = 0; i < DB + 2; i++) begin q_run.push_back(0); q_clr.push_back(0); end
      return;
    end
    run_ev  = m_ev[0];
    clr_ev  = m_ev[1] && !m_ev[0];
    run_now = (m_state == 1 || m_state == 2);
    if (m_state == 3) m_run_total = 0;
    else if (run_now) m_run_total++;
    case (m_state)
      0: if (run_ev) m_state = 1; else if (clr_ev) m_state = 3;
      1: if (run_ev) m_state = 0; else if (clr_ev) begin m_state = 2; m_lap = sw.i_count; end
      2: if (run_ev) m_state = 0; else if (clr_ev) m_state = 1;
      default: m_state = 0;
    endcase
    q_run.push_back(sw.btn_run);
    q_clr.push_back(sw.btn_clr);
    m_ev = '{0, 0};
    if (window_flips(q_run, m_db[0])) begin m_db[0] = !m_db[0]; m_ev[0] = m_db[0]; end
    if (window_flips(q_clr, m_db[1])) begin m_db[1] = !m_db[1]; m_ev[1] = m_db[1]; end
    while (q_run.size() > DB + 4) void'(q_run.pop_front());
    while (q_clr.size() > DB + 4) void'(q_clr.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    bit run_now;
    run_now = (m_state == 1 || m_state == 2);
    chk("model.state",  32'(sw.o_state),  32'(m_state));
    chk("model.run_on", 32'(sw.o_run_on), 32'(run_now));
    chk("model.clr_on", 32'(sw.o_clr_on), 32'(m_state == 3));
    chk("model.lap",    32'(sw.o_lap),    32'(m_state == 2));
    chk("model.tick",   32'(sw.o_tick),   32'(run_now && (m_run_total % DIV) == DIV - 1));
    chk("model.digit",  32'(sw.o_digit),  32'((m_state == 2) ? m_lap : sw.i_count));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_model();
      if (sw.o_tick === 1'b1) tick_log.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sw.btn_run = 1'b0; sw.btn_clr = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        run;
    logic        clr;
    logic [13:0] cnt;
    int          cycles;
    logic [1:0]  st;
    logic        run_on;
    logic        clr_on;
    logic        lap;
    logic [13:0] digit;
  } vec_t;

  vec_t vec [14];
  int   t_e, t_f, t_g;
  int   hold_r, hold_c;

  initial begin
    vec[0]  = '{1'b1, 1'b0, 14'h123,  6, 2'd0, 1'b0, 1'b0, 1'b0, 14'h123};
    vec[1]  = '{1'b1, 1'b0, 14'h123,  1, 2'd1, 1'b1, 1'b0, 1'b0, 14'h123};
    vec[2]  = '{1'b0, 1'b0, 14'h123, 10, 2'd1, 1'b1, 1'b0, 1'b0, 14'h123};
    vec[3]  = '{1'b0, 1'b1, 14'h123,  7, 2'd2, 1'b1, 1'b0, 1'b1, 14'h123};
    vec[4]  = '{1'b0, 1'b1, 14'h200,  3, 2'd2, 1'b1, 1'b0, 1'b1, 14'h123};
    vec[5]  = '{1'b0, 1'b0, 14'h201, 10, 2'd2, 1'b1, 1'b0, 1'b1, 14'h123};
    vec[6]  = '{1'b0, 1'b1, 14'h202,  6, 2'd2, 1'b1, 1'b0, 1'b1, 14'h123};
    vec[7]  = '{1'b0, 1'b1, 14'h202,  1, 2'd1, 1'b1, 1'b0, 1'b0, 14'h202};
    vec[8]  = '{1'b0, 1'b0, 14'h203, 10, 2'd1, 1'b1, 1'b0, 1'b0, 14'h203};
    vec[9]  = '{1'b1, 1'b0, 14'h204,  7, 2'd0, 1'b0, 1'b0, 1'b0, 14'h204};
    vec[10] = '{1'b0, 1'b0, 14'h204, 10, 2'd0, 1'b0, 1'b0, 1'b0, 14'h204};
    vec[11] = '{1'b0, 1'b1, 14'h204,  7, 2'd3, 1'b0, 1'b1, 1'b0, 14'h204};
    vec[12] = '{1'b0, 1'b1, 14'h204,  1, 2'd0, 1'b0, 1'b0, 1'b0, 14'h204};
    vec[13] = '{1'b0, 1'b0, 14'h205, 10, 2'd0, 1'b0, 1'b0, 1'b0, 14'h205};

    clk = 1'b0; reset = 1'b1;
    sw.btn_run = 1'b0; sw.btn_clr = 1'b0; sw.i_count = 14'h123;
    step(2);
    chk("reset.state",  32'(sw.o_state),  32'd0);
    chk("reset.run_on", 32'(sw.o_run_on), 32'd0);
    chk("reset.clr_on", 32'(sw.o_clr_on), 32'd0);
    chk("reset.tick",   32'(sw.o_tick),   32'd0);
    chk("reset.lap",    32'(sw.o_lap),    32'd0);
    chk("reset.digit",  32'(sw.o_digit),  32'h123);
    reset = 1'b0;

    foreach (vec[i]) begin
      sw.btn_run = vec[i].run; sw.btn_clr = vec[i].clr; sw.i_count = vec[i].cnt;
      step(vec[i].cycles);
      chk($sformatf("vec%0d.state", i),  32'(sw.o_state),  32'(vec[i].st));
      chk($sformatf("vec%0d.run_on", i), 32'(sw.o_run_on), 32'(vec[i].run_on));
      chk($sformatf("vec%0d.clr_on", i), 32'(sw.o_clr_on), 32'(vec[i].clr_on));
      chk($sformatf("vec%0d.lap", i),    32'(sw.o_lap),    32'(vec[i].lap));
      chk($sformatf("vec%0d.digit", i),  32'(sw.o_digit),  32'(vec[i].digit));
    end

    // Tick spacing, fraction kept across STOP, and prescaler zeroed by CLEAR.
    do_reset();
    sw.btn_run = 1'b1; step(7);
    chk("tick.enter_run", 32'(sw.o_state), 32'd1);
    t_e = cyc; tick_log.delete();
    sw.btn_run = 1'b0; step(10);
    sw.btn_run = 1'b1; step(7);
    chk("tick.stop_after_17", 32'(sw.o_state), 32'd0);
    chk("tick.first_count", 32'(tick_log.size()), 32'd1);
    if (tick_log.size() > 0) chk("tick.first_at", 32'(tick_log[0] - t_e), 32'd9);
    sw.btn_run = 1'b0; step(6);
    sw.btn_run = 1'b1; step(7);
    chk("tick.resume", 32'(sw.o_state), 32'd1);
    t_f = cyc; tick_log.delete();
    sw.btn_run = 1'b0; step(13);
    chk("tick.resume_count", 32'(tick_log.size()), 32'd2);
    if (tick_log.size() == 2) begin
      chk("tick.resume_first", 32'(tick_log[0] - t_f), 32'd2);
      chk("tick.resume_second", 32'(tick_log[1] - t_f), 32'd12);
    end
    sw.btn_run = 1'b1; step(7);
    chk("clr.stopped", 32'(sw.o_state), 32'd0);
    sw.btn_run = 1'b0; step(6);
    sw.btn_clr = 1'b1; step(7);
    chk("clr.state3", 32'(sw.o_state), 32'd3);
    chk("clr.pulse", 32'(sw.o_clr_on), 32'd1);
    step(1);
    chk("clr.back_stop", 32'(sw.o_state), 32'd0);
    chk("clr.pulse_end", 32'(sw.o_clr_on), 32'd0);
    sw.btn_clr = 1'b0; step(6);
    sw.btn_run = 1'b1; step(7);
    t_g = cyc; tick_log.delete();
    sw.btn_run = 1'b0; step(10);
    chk("clr.tick_count", 32'(tick_log.size()), 32'd1);
    if (tick_log.size() > 0) chk("clr.tick_at", 32'(tick_log[0] - t_g), 32'd9);

    // Short glitch, then bounce followed by a stable press.
    do_reset();
    sw.btn_run = 1'b1; step(3);
    sw.btn_run = 1'b0; step(10);
    chk("glitch.no_event", 32'(sw.o_state), 32'd0);
    for (int i = 0; i < 4; i++) begin sw.btn_run = (i % 2 == 0); step(1); end
    sw.btn_run = 1'b1; step(6);
    chk("bounce.before", 32'(sw.o_state), 32'd0);
    step(1);
    chk("bounce.event", 32'(sw.o_state), 32'd1);
    step(20);
    chk("bounce.single", 32'(sw.o_state), 32'd1);

    // Both presses land together.
    do_reset();
    sw.btn_run = 1'b1; sw.btn_clr = 1'b1; step(7);
    chk("both.state", 32'(sw.o_state), 32'd1);
    chk("both.lap", 32'(sw.o_lap), 32'd0);
    sw.btn_run = 1'b0; sw.btn_clr = 1'b0; step(10);
    chk("both.hold", 32'(sw.o_state), 32'd1);

    // Reset while in LAP with clear still held.
    do_reset();
    sw.btn_run = 1'b1; step(7);
    sw.btn_run = 1'b0; step(8);
    sw.i_count = 14'h0777;
    sw.btn_clr = 1'b1; step(7);
    chk("rlap.in_lap", 32'(sw.o_state), 32'd2);
    sw.i_count = 14'h0778;
    reset = 1'b1; step(1);
    chk("rlap.state", 32'(sw.o_state), 32'd0);
    chk("rlap.run_on", 32'(sw.o_run_on), 32'd0);
    chk("rlap.lap", 32'(sw.o_lap), 32'd0);
    chk("rlap.tick", 32'(sw.o_tick), 32'd0);
    chk("rlap.digit", 32'(sw.o_digit), 32'h0778);
    reset = 1'b0; step(6);
    chk("rlap.wait", 32'(sw.o_state), 32'd0);
    step(1);
    chk("rlap.clear", 32'(sw.o_state), 32'd3);
    step(1);
    chk("rlap.stop", 32'(sw.o_state), 32'd0);

    // Random buttons, count and occasional reset against the model.
    do_reset();
    hold_r = 0; hold_c = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_r == 0) begin sw.btn_run = 1'($urandom_range(0, 1)); hold_r = int'($urandom_range(1, 14)); end
      if (hold_c == 0) begin sw.btn_clr = 1'($urandom_range(0, 1)); hold_c = int'($urandom_range(1, 14)); end
      hold_r--; hold_c--;
      if ($urandom_range(0, 3) == 0) sw.i_count = (sw.i_count >= 14'd9999) ? 14'd0 : sw.i_count + 14'd1;
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
